// File: rtl/q_timing_pkg.sv
// Shared types and default widths for the timed quantum issue queue.
package q_timing_pkg;

  localparam int unsigned QT_INST_W = 64;
  localparam int unsigned QT_TIME_W = 32;
  localparam int unsigned QT_DEPTH  = 16;
  localparam int unsigned QT_NUM_CH = 4;
  localparam int unsigned QT_CH_LSB = 56;
  localparam int unsigned QT_CH_W   = $clog2(QT_NUM_CH);

  // Default-width layout of a queued entry; the top mirrors it at its own parameter widths.
  typedef struct packed {
    logic [QT_TIME_W-1:0] tag;
    logic [QT_CH_W-1:0]   ch;
    logic [QT_INST_W-1:0] inst;
  } qt_entry_t;

  typedef enum logic {
    QT_IDLE = 1'b0,
    QT_RUN  = 1'b1
  } qt_state_e;

endpackage

// File: rtl/qt_sync_fifo.sv
// Synchronous FIFO with a registered head word, registered status and a synchronous flush.
module qt_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [LW-1:0]    level_n;
  logic             do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    rd_ptr_n = rd_ptr + AW'(do_rd);
    level_n  = level + LW'(do_wr) - LW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // A write lands on the new head only when it is the sole remaining entry.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ready  <= 1'b1;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_wr);
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      full   <= (level_n == LW'(DEPTH));
      empty  <= (level_n == '0);
      ready  <= (level_n != LW'(DEPTH));
      head   <= (do_wr && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/q_timing_queue.sv
// Timed issue buffer: tags pushed instructions with an accumulated QWAIT timestamp and
// releases each one on its channel when the running timeline reaches the tag.
module q_timing_queue
  import q_timing_pkg::*;
#(
  parameter int unsigned INST_W = QT_INST_W,
  parameter int unsigned TIME_W = QT_TIME_W,
  parameter int unsigned DEPTH  = QT_DEPTH,
  parameter int unsigned NUM_CH = QT_NUM_CH,
  parameter int unsigned CH_LSB = QT_CH_LSB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     wait_valid,
  input  logic [TIME_W-1:0]        wait_cycles,
  input  logic                     push_valid,
  input  logic [INST_W-1:0]        push_inst,
  output logic                     push_ready,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic [INST_W-1:0]        ch_inst,
  output logic [TIME_W-1:0]        ch_time,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     running,
  output logic                     ovf_err,
  output logic                     late_err
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  typedef struct packed {
    logic [TIME_W-1:0] tag;
    logic [CH_W-1:0]   ch;
    logic [INST_W-1:0] inst;
  } entry_t;

  qt_state_e         state_q, state_d;
  logic [TIME_W-1:0] time_acc, timeline, delta_c;
  entry_t            push_ent_c, head;
  logic              flush_c, pop_c, late_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= QT_IDLE;
    else     state_q <= state_d;
  end

  // stop takes priority and flushes; start only matters from IDLE.
  always_comb begin
    state_d = state_q;
    flush_c = 1'b0;
    if (stop) begin
      state_d = QT_IDLE;
      flush_c = 1'b1;
    end else if (start && (state_q == QT_IDLE)) begin
      state_d = QT_RUN;
    end
  end

  // Tag includes a same-cycle wait; issue when the signed distance to the head tag is <= 0.
  always_comb begin
    push_ent_c.tag  = wait_valid ? (time_acc + wait_cycles) : time_acc;
    push_ent_c.ch   = push_inst[CH_LSB +: CH_W];
    push_ent_c.inst = push_inst;
    delta_c         = head.tag - timeline;
    late_c          = delta_c[TIME_W-1];
    pop_c           = (state_q == QT_RUN) && !stop && !empty && (late_c || (delta_c == '0));
  end

  qt_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_c),
    .wr_en   (push_valid),
    .wr_data (push_ent_c),
    .rd_en   (pop_c),
    .head    (head),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .ready   (push_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_valid <= '0;
      ch_inst  <= '0;
      ch_time  <= '0;
      ovf_err  <= 1'b0;
      late_err <= 1'b0;
      time_acc <= '0;
      timeline <= '0;
    end else begin
      ch_valid <= pop_c ? (NUM_CH'(1'b1) << head.ch) : '0;
      if (pop_c) begin
        ch_inst <= head.inst;
        ch_time <= head.tag;
        if (late_c) late_err <= 1'b1;
      end
      if (push_valid && full) ovf_err <= 1'b1;
      if (stop)            time_acc <= '0;
      else if (wait_valid) time_acc <= time_acc + wait_cycles;
      timeline <= ((state_q == QT_RUN) && !stop) ? (timeline + TIME_W'(1'b1)) : '0;
    end
  end

  assign running = (state_q == QT_RUN);

endmodule

// File: tb/tb_q_timing_queue.sv
// Bench for q_timing_queue: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, a TIME_W=8 wrap instance and a randomized phase.
`timescale 1ns/1ps
module tb_q_timing_queue;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop, wait_valid, push_valid;
  logic [31:0] wait_cycles;
  logic [63:0] push_inst;
  logic        push_ready, empty, full, running, ovf_err, late_err;
  logic [3:0]  ch_valid;
  logic [63:0] ch_inst;
  logic [31:0] ch_time;
  logic [4:0]  level;

  logic        start8, stop8, wait_valid8, push_valid8;
  logic [7:0]  wait_cycles8;
  logic [63:0] push_inst8;
  logic        push_ready8, empty8, full8, running8, ovf_err8, late_err8;
  logic [3:0]  ch_valid8;
  logic [63:0] ch_inst8;
  logic [7:0]  ch_time8;
  logic [4:0]  level8;

  q_timing_queue dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .wait_valid(wait_valid), .wait_cycles(wait_cycles),
    .push_valid(push_valid), .push_inst(push_inst), .push_ready(push_ready),
    .ch_valid(ch_valid), .ch_inst(ch_inst), .ch_time(ch_time), .level(level),
    .empty(empty), .full(full), .running(running), .ovf_err(ovf_err), .late_err(late_err)
  );

  q_timing_queue #(.TIME_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .stop(stop8),
    .wait_valid(wait_valid8), .wait_cycles(wait_cycles8),
    .push_valid(push_valid8), .push_inst(push_inst8), .push_ready(push_ready8),
    .ch_valid(ch_valid8), .ch_inst(ch_inst8), .ch_time(ch_time8), .level(level8),
    .empty(empty8), .full(full8), .running(running8), .ovf_err(ovf_err8), .late_err(late_err8)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: an ordered list of tagged entries plus timeline/accumulator integers.
  typedef struct {
    logic [31:0] tag;
    logic [1:0]  ch;
    logic [63:0] inst;
  } ment_t;

  ment_t       mq[$];
  bit          m_run, m_ovf, m_late, started;
  bit          m_pop;
  logic [31:0] m_tl, m_acc, m_time, m_d;
  logic [63:0] m_inst;
  logic [3:0]  m_v;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (rst) begin
      mq.delete();
      m_run = 0; m_tl = 0; m_acc = 0; m_time = 0; m_inst = 0; m_v = 0; m_ovf = 0; m_late = 0;
    end else begin
      m_pop = 0;
      m_v   = 4'd0;
      if (m_run && !stop && (mq.size() > 0)) begin
        m_d = mq[0].tag - m_tl;
        if ($signed(m_d) <= 0) begin
          m_pop  = 1;
          m_v    = 4'd1 << mq[0].ch;
          m_inst = mq[0].inst;
          m_time = mq[0].tag;
          if ($signed(m_d) < 0) m_late = 1;
        end
      end
      if (push_valid) begin
        if (mq.size() == DEPTH) m_ovf = 1;
        else mq.push_back('{tag: m_acc + (wait_valid ? wait_cycles : 32'd0),
                            ch: push_inst[57:56], inst: push_inst});
      end
      if (m_pop) void'(mq.pop_front());
      if (wait_valid) m_acc = m_acc + wait_cycles;
      if (stop) begin
        m_acc = 0; mq.delete(); m_run = 0; m_tl = 0;
      end else if (m_run) begin
        m_tl = m_tl + 32'd1;
      end else begin
        m_tl = 0;
        if (start) m_run = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ch_valid",   64'(ch_valid),   64'(m_v));
      chk("ch_inst",    ch_inst,         m_inst);
      chk("ch_time",    64'(ch_time),    64'(m_time));
      chk("level",      64'(level),      64'(mq.size()));
      chk("empty",      64'(empty),      64'(mq.size() == 0));
      chk("full",       64'(full),       64'(mq.size() == DEPTH));
      chk("push_ready", 64'(push_ready), 64'(mq.size() != DEPTH));
      chk("running",    64'(running),    64'(m_run));
      chk("ovf_err",    64'(ovf_err),    64'(m_ovf));
      chk("late_err",   64'(late_err),   64'(m_late));
    end
  end

  // Issue log: cycle number of the edge that produced each pulse.
  typedef struct {
    int          c;
    logic [3:0]  v;
    logic [31:0] t;
  } iss_t;

  iss_t log_q[$], log8_q[$];

  always @(negedge clk) begin
    if (ch_valid != 4'd0)  log_q.push_back('{cyc, ch_valid, ch_time});
    if (ch_valid8 != 4'd0) log8_q.push_back('{cyc, ch_valid8, 32'(ch_time8)});
  end

  function automatic iss_t lg(input int i);
    if (i < log_q.size()) return log_q[i];
    return '{-1, 4'd0, 32'd0};
  endfunction

  function automatic iss_t lg8(input int i);
    if (i < log8_q.size()) return log8_q[i];
    return '{-1, 4'd0, 32'd0};
  endfunction

  task automatic clr();
    start = 0; stop = 0; wait_valid = 0; wait_cycles = '0; push_valid = 0; push_inst = '0;
    start8 = 0; stop8 = 0; wait_valid8 = 0; wait_cycles8 = '0; push_valid8 = 0; push_inst8 = '0;
  endtask

  task automatic step();
    @(negedge clk);
    clr();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_until(input int target);
    for (int k = 0; k < 1000 && cyc < target; k++) step();
    chk("sync", 64'(cyc), 64'(target));
  endtask

  function automatic logic [63:0] mk_inst(input logic [1:0] ch);
    logic [63:0] x;
    x = {$urandom, $urandom};
    x[57:56] = ch;
    return x;
  endfunction

  int          e0;
  logic [63:0] inst_a;

  initial begin
    rst = 1'b1;
    clr();
    idle(3);
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_empty",      64'(empty),      64'd1);
    chk("rst_level",      64'(level),      64'd0);
    chk("rst_ch_valid",   64'(ch_valid),   64'd0);
    chk("rst_running",    64'(running),    64'd0);
    chk("rst_ovf",        64'(ovf_err),    64'd0);
    chk("rst_late",       64'(late_err),   64'd0);

    // wait 10, push on ch1, start: issue exactly at E0+11
    step(); wait_valid = 1; wait_cycles = 32'd10;
    step(); push_valid = 1; inst_a = mk_inst(2'd1); push_inst = inst_a;
    step(); start = 1; e0 = cyc + 1; log_q.delete();
    wait_until(e0 + 14);
    chk("t2_count", 64'(log_q.size()), 64'd1);
    chk("t2_cycle", 64'(lg(0).c),      64'(e0 + 11));
    chk("t2_chv",   64'(lg(0).v),      64'b0010);
    chk("t2_time",  64'(lg(0).t),      64'd10);
    chk("t2_inst",  ch_inst,           inst_a);
    chk("t2_late",  64'(late_err),     64'd0);
    stop = 1;
    step();

    // Equal tags: A on time, B one cycle later and late
    step(); wait_valid = 1; wait_cycles = 32'd5;
    step(); push_valid = 1; push_inst = mk_inst(2'd0);
    step(); push_valid = 1; push_inst = mk_inst(2'd2);
    step(); start = 1; e0 = cyc + 1; log_q.delete();
    wait_until(e0 + 12);
    chk("t3_count", 64'(log_q.size()), 64'd2);
    chk("t3_a_cyc", 64'(lg(0).c),      64'(e0 + 6));
    chk("t3_a_chv", 64'(lg(0).v),      64'b0001);
    chk("t3_b_cyc", 64'(lg(1).c),      64'(e0 + 7));
    chk("t3_b_chv", 64'(lg(1).v),      64'b0100);
    chk("t3_b_tag", 64'(lg(1).t),      64'd5);
    chk("t3_late",  64'(late_err),     64'd1);
    stop = 1;
    step();

    // Fill to 16 in IDLE, 17th overflows
    for (int i = 0; i < 16; i++) begin
      step(); push_valid = 1; push_inst = mk_inst(2'($urandom_range(0, 3)));
    end
    step();
    chk("t4_full",  64'(full),       64'd1);
    chk("t4_ready", 64'(push_ready), 64'd0);
    chk("t4_level", 64'(level),      64'd16);
    chk("t4_ovf0",  64'(ovf_err),    64'd0);
    push_valid = 1; push_inst = mk_inst(2'd3);
    step();
    chk("t4_ovf1",   64'(ovf_err), 64'd1);
    chk("t4_level2", 64'(level),   64'd16);
    stop = 1;
    step();
    chk("t4_flush", 64'(empty), 64'd1);

    // Push and pop in the same cycle with level 3
    step(); wait_valid = 1; wait_cycles = 32'd20; push_valid = 1; push_inst = mk_inst(2'd0);
    step(); push_valid = 1; push_inst = mk_inst(2'd1);
    step(); push_valid = 1; push_inst = mk_inst(2'd2);
    step(); start = 1; e0 = cyc + 1; log_q.delete();
    wait_until(e0 + 20);
    chk("t5_level_pre", 64'(level), 64'd3);
    push_valid = 1; push_inst = mk_inst(2'd3);
    step();
    chk("t5_level_post", 64'(level), 64'd3);
    wait_until(e0 + 25);
    chk("t5_first_cyc", 64'(lg(0).c),      64'(e0 + 21));
    chk("t5_first_chv", 64'(lg(0).v),      64'b0001);
    chk("t5_count",     64'(log_q.size()), 64'd4);
    stop = 1;
    step();

    // rst mid-RUN with 5 far-future entries
    step(); wait_valid = 1; wait_cycles = 32'd1000; push_valid = 1; push_inst = mk_inst(2'd1);
    for (int i = 0; i < 4; i++) begin
      step(); push_valid = 1; push_inst = mk_inst(2'd2);
    end
    step(); start = 1;
    idle(5);
    chk("t6_level_pre", 64'(level),   64'd5);
    chk("t6_run_pre",   64'(running), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_empty", 64'(empty),   64'd1);
    chk("t6_run",   64'(running), 64'd0);
    chk("t6_level", 64'(level),   64'd0);
    log_q.delete();
    idle(20);
    chk("t6_no_issue", 64'(log_q.size()), 64'd0);

    // TIME_W=8 wrap: tags 250 and 4 issue 10 cycles apart, both on time
    step(); start8 = 1; e0 = cyc + 1; log8_q.delete();
    wait_until(e0 + 200);
    wait_valid8 = 1; wait_cycles8 = 8'd250; push_valid8 = 1; push_inst8 = mk_inst(2'd0);
    step(); wait_valid8 = 1; wait_cycles8 = 8'd10; push_valid8 = 1; push_inst8 = mk_inst(2'd1);
    wait_until(e0 + 270);
    chk("t7_count", 64'(log8_q.size()), 64'd2);
    chk("t7_a_cyc", 64'(lg8(0).c),      64'(e0 + 251));
    chk("t7_a_tag", 64'(lg8(0).t),      64'd250);
    chk("t7_b_cyc", 64'(lg8(1).c),      64'(e0 + 261));
    chk("t7_b_tag", 64'(lg8(1).t),      64'd4);
    chk("t7_b_chv", 64'(lg8(1).v),      64'b0010);
    chk("t7_late",  64'(late_err8),     64'd0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      step();
      rst         = ($urandom_range(0, 999) == 0);
      start       = ($urandom_range(0, 29) == 0);
      stop        = ($urandom_range(0, 149) == 0);
      wait_valid  = ($urandom_range(0, 3) == 0);
      wait_cycles = 32'($urandom_range(0, 6));
      push_valid  = ($urandom_range(0, 1) == 1);
      push_inst   = mk_inst(2'($urandom_range(0, 3)));
    end
    step();
    rst = 1'b0;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
